dmem_responder: RTL and testbench

- Data-memory responder serving the pipelined CPU's load/store port, which is the initiator.
- Accepts one request per transaction on the CPU_MIO / dm_write / address / data / DMType signals.
- Performs a sub-word-aware read or write on an internal word-organised array.
- Completes each transaction by pulsing MIO_ready with load data after a configurable number of wait states.

---
 rtl/dm_pkg.sv | 16 +
 rtl/dm_lane_align.sv | 54 +++++
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access types and FSM states.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// lane extraction with sign/zero extension for loads, and the misalignment flag.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_dm_type,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_sh,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shift;
    logic [15:0] w_half;

    assign w_shift = i_rword >> {i_addr_lo, 3'b000};
    assign w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_misalign = 1'b0;
        o_be       = 4'b0000;
        o_wdata_sh = i_wdata;
        o_rdata    = 32'd0;
        case (i_dm_type)
            DM_HALF, DM_HALF_U: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_sh = {2{i_wdata[15:0]}};
                o_rdata    = (i_dm_type == DM_HALF) ? {{16{w_half[15]}}, w_half}
                                                    : {16'd0, w_half};
            end
            DM_BYTE, DM_BYTE_U: begin
                o_be       = 4'b0001 << i_addr_lo;
                o_wdata_sh = {4{i_wdata[7:0]}};
                o_rdata    = (i_dm_type == DM_BYTE) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                                    : {24'd0, w_shift[7:0]};
            end
            default: begin
                // Reserved encodings behave as word accesses.
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
                o_rdata    = i_rword;
            end
        endcase
        if (o_misalign) begin
            o_be    = 4'b0000;
            o_rdata = 32'd0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a CPU load/store, waits WAIT_CYCLES, then pulses
// o_mio_ready with aligned/extended load data. Stores commit on the edge leaving RESP.
module dmem_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_mio,
    input  logic        i_dm_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_dm_type,
    output logic [31:0] o_rdata,
    output logic        o_mio_ready,
    output logic        o_misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [2:0]  r_type;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_misalign;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0] w_addr;
    logic        w_write;
    logic [31:0] w_wdata;
    logic [2:0]  w_type;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_ld_data;
    logic        w_misalign;
    logic [31:0] w_resp_data;

    // In IDLE the live request feeds the datapath so a zero-wait access responds next cycle.
    assign w_addr      = (r_state == S_IDLE) ? i_addr     : r_addr;
    assign w_write     = (r_state == S_IDLE) ? i_dm_write : r_write;
    assign w_wdata     = (r_state == S_IDLE) ? i_wdata    : r_wdata;
    assign w_type      = (r_state == S_IDLE) ? i_dm_type  : r_type;
    assign w_rword     = r_mem[w_addr[AW+1:2]];
    assign w_resp_data = w_write ? 32'd0 : w_ld_data;

    dm_lane_align u_align (
        .i_addr_lo  (w_addr[1:0]),
        .i_dm_type  (w_type),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata_sh (w_wdata_sh),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
            r_type     <= DM_WORD;
            r_rdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_ready    <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_mio) begin
                        r_addr  <= i_addr;
                        r_write <= i_dm_write;
                        r_wdata <= i_wdata;
                        r_type  <= i_dm_type;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state    <= S_RESP;
                            r_ready    <= 1'b1;
                            r_misalign <= w_misalign;
                            r_rdata    <= w_resp_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_cpu_mio) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state    <= S_RESP;
                        r_ready    <= 1'b1;
                        r_misalign <= w_misalign;
                        r_rdata    <= w_resp_data;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; a reset edge during RESP suppresses the commit.
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == S_RESP && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_addr[AW+1:2]][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata     = r_rdata;
    assign o_mio_ready = r_ready;
    assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for functional/abort cases and a
// WAIT_CYCLES=0 instance for back-to-back requests; expectations flow through a queue.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_mio, a_wr, b_mio, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [2:0]  a_type, b_type;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_mis, b_ready, b_mis;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_mio(a_mio), .i_dm_write(a_wr), .i_addr(a_addr),
        .i_wdata(a_wdata), .i_dm_type(a_type), .o_rdata(a_rdata), .o_mio_ready(a_ready),
        .o_misalign(a_mis)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cpu_mio(b_mio), .i_dm_write(b_wr), .i_addr(b_addr),
        .i_wdata(b_wdata), .i_dm_type(b_type), .o_rdata(b_rdata), .o_mio_ready(b_ready),
        .o_misalign(b_mis)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance; response expected on the 3rd negedge.
    task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] t,
                       input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        int   n;
        exp_q.push_back('{rdata: exp_rd, mis: exp_mis});
        @(negedge clk);
        a_mio = 1'b1; a_wr = wr; a_addr = a; a_wdata = wd; a_type = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ready && n < 20);
        check({tag, "_lat"}, 32'(n), 32'd3);
        e = exp_q.pop_front();
        check({tag, "_rdata"}, a_rdata, e.rdata);
        check({tag, "_mis"}, 32'(a_mis), 32'(e.mis));
        a_mio = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(a_ready), 32'd0);
    endtask

    initial begin
        int n, rdy_seen, cyc, last;
        exp_t e;
        logic [31:0] ba [5];
        logic        bw [5];
        logic [31:0] bd [5];
        logic [2:0]  bt [5];

        rst = 1'b1;
        a_mio = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_type = 3'b000;
        b_mio = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_type = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_mis", 32'(a_mis), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        rst = 1'b0;

        txn("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 1'b0);
        txn("ld_w10", 1'b0, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0);
        txn("st_b11", 1'b1, 32'h11, 32'h0000005A, 3'b011, 32'h0, 1'b0);
        txn("ld_w10b", 1'b0, 32'h10, 32'h0, 3'b000, 32'hDEAD5AEF, 1'b0);
        txn("ld_b11", 1'b0, 32'h11, 32'h0, 3'b011, 32'h0000005A, 1'b0);
        txn("ld_h12s", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
        txn("ld_h12u", 1'b0, 32'h12, 32'h0, 3'b010, 32'h0000DEAD, 1'b0);
        txn("st_b13", 1'b1, 32'h13, 32'hFFFFFF80, 3'b100, 32'h0, 1'b0);
        txn("ld_b13s", 1'b0, 32'h13, 32'h0, 3'b011, 32'hFFFFFF80, 1'b0);
        txn("ld_b13u", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000080, 1'b0);
        txn("st_w12mis", 1'b1, 32'h12, 32'hFFFFFFFF, 3'b000, 32'h0, 1'b1);
        txn("ld_w10c", 1'b0, 32'h10, 32'h0, 3'b000, 32'h80AD5AEF, 1'b0);
        txn("ld_h11mis", 1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1);
        txn("ld_alias", 1'b0, 32'h1010, 32'h0, 3'b000, 32'h80AD5AEF, 1'b0);
        txn("ld_type7", 1'b0, 32'h10, 32'h0, 3'b111, 32'h80AD5AEF, 1'b0);
        txn("st_w14", 1'b1, 32'h14, 32'hAABBCCDD, 3'b000, 32'h0, 1'b0);
        txn("st_h16", 1'b1, 32'h16, 32'hFFFF1234, 3'b010, 32'h0, 1'b0);
        txn("ld_w14", 1'b0, 32'h14, 32'h0, 3'b000, 32'h1234CCDD, 1'b0);

        // Reset during WAIT abandons the store.
        @(negedge clk);
        a_mio = 1'b1; a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'h11111111; a_type = 3'b000;
        @(negedge clk);
        rst = 1'b1; a_mio = 1'b0;
        @(negedge clk);
        check("rstw_ready", 32'(a_ready), 32'd0);
        check("rstw_mis", 32'(a_mis), 32'd0);
        check("rstw_rdata", a_rdata, 32'd0);
        rst = 1'b0;
        rdy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_ready) rdy_seen++;
        end
        check("rstw_noresp", 32'(rdy_seen), 32'd0);
        txn("ld_after_rst", 1'b0, 32'h10, 32'h0, 3'b000, 32'h80AD5AEF, 1'b0);

        // Dropping cpu_mio mid-WAIT aborts without a write.
        @(negedge clk);
        a_mio = 1'b1; a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'h22222222; a_type = 3'b000;
        @(negedge clk);
        a_mio = 1'b0;
        rdy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_ready) rdy_seen++;
        end
        check("abort_noresp", 32'(rdy_seen), 32'd0);
        txn("ld_after_abort", 1'b0, 32'h10, 32'h0, 3'b000, 32'h80AD5AEF, 1'b0);

        // Back-to-back on the zero-wait instance with cpu_mio held high throughout.
        ba = '{32'h10, 32'h14, 32'h10, 32'h14, 32'h15};
        bw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bd = '{32'h01020304, 32'h05060708, 32'h0, 32'h0, 32'h0};
        bt = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
        exp_q.push_back('{rdata: 32'h0, mis: 1'b0});
        exp_q.push_back('{rdata: 32'h0, mis: 1'b0});
        exp_q.push_back('{rdata: 32'h01020304, mis: 1'b0});
        exp_q.push_back('{rdata: 32'h05060708, mis: 1'b0});
        exp_q.push_back('{rdata: 32'h00000007, mis: 1'b0});
        @(negedge clk);
        cyc = 0;
        last = -1;
        b_mio = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_wr = bw[k]; b_addr = ba[k]; b_wdata = bd[k]; b_type = bt[k];
            n = 0;
            do begin
                @(negedge clk);
                cyc++;
                n++;
                if (n == 1 && k > 0) check("b2b_gap_low", 32'(b_ready), 32'd0);
            end while (!b_ready && n < 20);
            check($sformatf("b2b_lat%0d", k), 32'(n), (k == 0) ? 32'd1 : 32'd2);
            if (last >= 0) check($sformatf("b2b_period%0d", k), 32'(cyc - last), 32'd2);
            last = cyc;
            e = exp_q.pop_front();
            check($sformatf("b2b_rdata%0d", k), b_rdata, e.rdata);
            check($sformatf("b2b_mis%0d", k), 32'(b_mis), 32'(e.mis));
        end
        b_mio = 1'b0;
        @(negedge clk);
        check("b2b_end_low", 32'(b_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
